// File: rtl/opc_stage_pkg.sv
// Shared definitions for the opcode/control stage registers.
// Holds the word width, field positions, the bubble word and the
// common three-state occupancy enum used by every skid stage.
package opc_stage_pkg;

    // Opcode/control word width.
    localparam int OPC_W = 18;

    // Field positions inside the opcode/control word.
    localparam int OPC_OPCODE_MSB = 17;
    localparam int OPC_OPCODE_LSB = 12;
    localparam int OPC_DEST_MSB   = 11;
    localparam int OPC_DEST_LSB   = 7;
    localparam int OPC_FLAGS_MSB  = 6;
    localparam int OPC_FLAGS_LSB  = 0;
    localparam int OPC_REG_WRITE  = 0;

    // Word presented downstream when nothing valid is held.
    localparam logic [OPC_W-1:0] BUBBLE = 18'h00000;

    // Occupancy of a main + skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/opc_stall_counter.sv
// Saturating stall-cycle counter.
// Counts cycles in which inc is high and sticks at all-ones.
// Cleared only by the asynchronous active-low reset.
module opc_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Increment on each stalled cycle until the counter is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/opc_stage3_skid_reg.sv
// Stage-3 to stage-4 opcode/control pipeline register.
// Valid/ready handshake with a one-entry skid buffer so a downstream
// stall never drops a word and in_ready never depends combinationally
// on out_ready. flush turns every held word into a bubble.
// Optional feature: define OPC_STAGE3_STALL_CNT_EN to add the
// saturating stall_cnt output (cycles with out_valid=1, out_ready=0).
module opc_stage3_skid_reg
    import opc_stage_pkg::*;
#(
    parameter int W = OPC_W
`ifdef OPC_STAGE3_STALL_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [W-1:0]     in_word,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_word,
    input  logic             out_ready
`ifdef OPC_STAGE3_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    stage_state_e state, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_ready_q;
    logic         accept;
    logic         drain;

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    // main is cleared whenever it empties, the gate only guarantees the bubble.
    assign out_word  = out_valid ? main_q : '0;

    // State, storage and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            // in_ready is the decode of the next state, taken from a flop.
            in_ready_q <= (state_d != TWO);
        end
    end

    // Next-state and storage update; flush overrides every other event.
    always_comb begin
        state_d = state;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = in_word;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_word;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_word;
                    end else if (drain) begin
                        state_d = EMPTY;
                        main_d  = '0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

`ifdef OPC_STAGE3_STALL_CNT_EN
    opc_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_opc_stage3_skid_reg.sv
// Self-checking bench for opc_stage3_skid_reg.
// Table-driven directed vectors, hand-written corner sequences and a
// randomized phase against a queue-based reference model.
module tb_opc_stage3_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [17:0] in_word = '0;
    logic        in_ready;
    logic        out_valid;
    logic [17:0] out_word;
    logic        out_ready = 1'b0;
`ifdef OPC_STAGE3_STALL_CNT_EN
    logic [3:0]  stall_cnt;
`endif

    always #5 clk = ~clk;

    opc_stage3_skid_reg #(
        .W     (18)
`ifdef OPC_STAGE3_STALL_CNT_EN
        ,
        .CNT_W (4)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_word   (in_word),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_ready (out_ready)
`ifdef OPC_STAGE3_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: FIFO of at most two words plus a stall count.
    logic [17:0] mq[$];
    int unsigned m_cnt = 0;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [17:0] w;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [17:0] e_word;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance one edge, update the model.
    task automatic tick(input logic fl, input logic iv, input logic [17:0] iw, input logic ordy);
        logic m_ready;
        logic m_valid;
        flush     = fl;
        in_valid  = iv;
        in_word   = iw;
        out_ready = ordy;
        @(posedge clk);
        m_ready = (mq.size() < 2);
        m_valid = (mq.size() > 0);
        if (m_valid && !ordy && m_cnt < 15) m_cnt++;
        if (fl) begin
            mq.delete();
        end else begin
            if (m_valid && ordy) void'(mq.pop_front());
            if (iv && m_ready) mq.push_back(iw);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [17:0] exp_word;
        exp_word = (mq.size() > 0) ? mq[0] : 18'h0;
        check({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (mq.size() < 2)});
        check({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, (mq.size() > 0)});
        check({tag, ".out_word"}, {14'b0, out_word}, {14'b0, exp_word});
`ifdef OPC_STAGE3_STALL_CNT_EN
        check({tag, ".stall_cnt"}, {28'b0, stall_cnt}, m_cnt);
`endif
    endtask

    initial begin
        // Directed table: {flush, in_valid, in_word, out_ready} -> {in_ready, out_valid, out_word}
        tbl[0]  = '{1'b0, 1'b1, 18'h0A001, 1'b1, 1'b1, 1'b1, 18'h0A001};
        tbl[1]  = '{1'b0, 1'b1, 18'h0B002, 1'b1, 1'b1, 1'b1, 18'h0B002};
        tbl[2]  = '{1'b0, 1'b1, 18'h0C003, 1'b1, 1'b1, 1'b1, 18'h0C003};
        tbl[3]  = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00000};
        tbl[4]  = '{1'b0, 1'b1, 18'h11111, 1'b0, 1'b1, 1'b1, 18'h11111};
        tbl[5]  = '{1'b0, 1'b1, 18'h22222, 1'b0, 1'b0, 1'b1, 18'h11111};
        tbl[6]  = '{1'b0, 1'b1, 18'h3FFFF, 1'b0, 1'b0, 1'b1, 18'h11111};
        tbl[7]  = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b1, 18'h22222};
        tbl[8]  = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00000};
        tbl[9]  = '{1'b0, 1'b1, 18'h01234, 1'b0, 1'b1, 1'b1, 18'h01234};
        tbl[10] = '{1'b0, 1'b1, 18'h05678, 1'b0, 1'b0, 1'b1, 18'h01234};
        tbl[11] = '{1'b1, 1'b1, 18'h33333, 1'b1, 1'b1, 1'b0, 18'h00000};
        tbl[12] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b1, 1'b0, 18'h00000};

        // Reset held for three cycles, then idle outputs.
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", {31'b0, out_valid}, 32'd0);
        check("reset.out_word", {14'b0, out_word}, 32'd0);
        check("reset.in_ready", {31'b0, in_ready}, 32'd1);
`ifdef OPC_STAGE3_STALL_CNT_EN
        check("reset.stall_cnt", {28'b0, stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].fl, tbl[i].iv, tbl[i].w, tbl[i].ordy);
            check($sformatf("tbl%0d.in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].e_rdy});
            check($sformatf("tbl%0d.out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].e_vld});
            check($sformatf("tbl%0d.out_word", i), {14'b0, out_word}, {14'b0, tbl[i].e_word});
            check_model($sformatf("tbl%0d.model", i));
        end

        // Asynchronous reset between edges while one word is held.
        tick(1'b0, 1'b1, 18'h2A5A5, 1'b1);
        check("async.pre_word", {14'b0, out_word}, {14'b0, 18'h2A5A5});
        #3;
        rst_n = 1'b0;
        #1;
        mq.delete();
        m_cnt = 0;
        check("async.out_valid", {31'b0, out_valid}, 32'd0);
        check("async.out_word", {14'b0, out_word}, 32'd0);
        check("async.in_ready", {31'b0, in_ready}, 32'd1);
`ifdef OPC_STAGE3_STALL_CNT_EN
        check("async.stall_cnt", {28'b0, stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release accepts.
        tick(1'b0, 1'b1, 18'h1BEEF, 1'b1);
        check("release.out_word", {14'b0, out_word}, {14'b0, 18'h1BEEF});
        check_model("release");

        // Long stall with one word held: counter saturates, word holds.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 18'h0, 1'b0);
            check_model($sformatf("stall%0d", i));
        end
        check("stall.out_word", {14'b0, out_word}, {14'b0, 18'h1BEEF});
`ifdef OPC_STAGE3_STALL_CNT_EN
        check("stall.sat", {28'b0, stall_cnt}, 32'd15);
        // Flush leaves the counter untouched.
        tick(1'b1, 1'b0, 18'h0, 1'b0);
        check("stall.flush_keep", {28'b0, stall_cnt}, 32'd15);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                 18'($urandom), $urandom_range(0, 3) != 0 ? ($urandom_range(0, 1) == 1) : 1'b0);
            check_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/opc_stage3_skid_reg.md
# opc_stage3_skid_reg

Stage-3 to stage-4 pipeline register for the 18-bit opcode/control word. It carries the word produced by the execute stage into the stage-4 opcode register. It uses a valid/ready handshake with a one-entry skid buffer, so a downstream stall never drops a word and never creates a combinational ready path upstream. A synchronous flush converts all in-flight words into bubbles.

## Interface
- `W`, default 18: opcode/control word width. Bits [17:12] are the opcode, [11:7] the destination register, [6:0] the control flags; bit 0 is reg_write.
- `CNT_W`, default 16: stall counter width. Used only when the macro is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous squash of all held words.
- `in_valid`  in  1  upstream word valid.
- `in_word`  in  W  upstream opcode/control word.
- `in_ready`  out  1  module can accept a word this cycle. Registered.
- `out_valid`  out  1  `out_word` is valid.
- `out_word`  out  W  word presented to stage 4. Equals 18'h00000 when `out_valid`=0.
- `out_ready`  in  1  stage 4 accepts this cycle (stage-4 stall_n).
- `stall_cnt`  out  CNT_W  saturating stall-cycle count. Present only with the macro.

## Operation
- Storage is a main register (`main`, drives `out_word`) and a skid register (`skid`).
- State machine:
  - EMPTY: nothing held.
  - ONE: main valid.
  - TWO: main and skid valid.
- Output decode:
  - `in_ready` = (state != TWO).
  - `out_valid` = (state != EMPTY).
- Define accept = `in_valid` & `in_ready` and drain = `out_valid` & `out_ready`.
- Transitions with `flush`=0:
  - EMPTY:
    - accept → ONE, main<=`in_word`.
    - otherwise stay.
  - ONE:
    - accept & drain → stay ONE, main<=`in_word`.
    - accept & !drain → TWO, skid<=`in_word`.
    - !accept & drain → EMPTY, main<=0.
    - otherwise hold.
  - TWO:
    - drain → ONE, main<=skid, skid<=0.
    - otherwise hold. No accept is possible in TWO.
- Flush:
  - `flush`=1 takes priority over every event that cycle.
  - Next state is EMPTY, with main<=0 and skid<=0.
  - A word accepted in the flush cycle is discarded.
  - `in_ready` returns to 1 on the next cycle.
- Ordering: words leave in strict arrival order. No duplication, no loss.
- Word contents pass through unmodified. The module does no arithmetic on the word.

## Timing
- Reset (`rst_n`=0, asynchronous): state=EMPTY, main=0, skid=0.
  - Resulting outputs: `out_valid`=0, `out_word`=0, `in_ready`=1, `stall_cnt`=0.
- Latency: a word accepted at edge N appears on `out_word` after edge N, i.e. one cycle.
- Throughput: 1 word/cycle sustained while `out_ready`=1.
- Stall onset: with `out_ready` dropped for one cycle, at most one extra word is absorbed into skid. `in_ready` falls in the cycle after skid fills.
- Stall release: `in_ready` rises in the cycle after the drain from TWO.
- Simultaneous flush and drain: stage 4 still samples the current `out_word` that cycle. The drain is not suppressed, because stage 4 owns its own flush. The next state is EMPTY.
- Reset deasserted mid-stream: all held words are lost. The first accept is possible on the first edge after release.

## Configuration
- `OPC_STAGE3_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It counts cycles with `out_valid`=1 & `out_ready`=0.
  - It saturates at 2^CNT_W−1.
  - It resets to 0 via `rst_n` only; it is unaffected by `flush`.
- Not defined: the port and the counter logic are absent. The rest of the behaviour is identical.

## Structure
- Shared package `opc_stage_pkg` holds:
  - `OPC_W`=18.
  - The field position constants (opcode, dest, flags, reg_write bit).
  - The `BUBBLE` constant = 18'h00000.
  - The state enum (EMPTY, ONE, TWO), also used by the other stage registers.
- One sub-module, `opc_stall_counter`: the saturating counter. It is instantiated only under the macro.

## Test plan
- Reset then idle: `rst_n` low for 3 cycles → `out_valid`=0, `out_word`=0, `in_ready`=1, `stall_cnt`=0.
- Streaming: `out_ready`=1, push 18'h0A001, 18'h0B002, 18'h0C003 on consecutive cycles → they appear on `out_word` on consecutive cycles, each one cycle after its input.
- Stall and skid:
  - Push 18'h11111 and then 18'h22222 with `out_ready`=0 → state TWO, `in_ready`=0, `out_word`=18'h11111.
  - Raise `out_ready` → the next cycle shows 18'h22222, then `in_ready`=1.
- Flush in TWO: fill both entries, assert `flush` with `in_valid`=1 and word 18'h33333 → the next cycle has `out_valid`=0, `out_word`=0, `in_ready`=1, and 18'h33333 never appears.
- Async reset mid-stream: drop `rst_n` between edges while in ONE → outputs go to their reset values immediately, without waiting for a clock edge.
- Stall counter (macro, CNT_W=4): hold `out_valid`=1 with `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and stays at 15.
